// File: rtl/peak_bin_detector.sv
// Post-FFT peak finder: per-lane power, lane tournament, per-frame running argmax.
// Optional macro PBD_DC_EXCLUDE_EN forces bin 0 power to zero before reduction.
module peak_bin_detector #(
    parameter int BINS  = 16,
    parameter int LANES = 16,
    parameter int DW    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [LANES*DW-1:0]     in_re,
    input  logic [LANES*DW-1:0]     in_im,
    input  logic [2*DW:0]           thresh,
    output logic                    done,
    output logic [$clog2(BINS)-1:0] freq,
    output logic [2*DW:0]           peak_pwr,
    output logic                    hit
);
    localparam int PW    = 2 * DW + 1;
    localparam int FW    = $clog2(BINS);
    localparam int BEATS = BINS / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LSH   = $clog2(LANES);
    localparam int LW    = (LANES > 1) ? LSH : 1;
`ifdef PBD_DC_EXCLUDE_EN
    localparam bit DC_EXCL = 1'b1;
`else
    localparam bit DC_EXCL = 1'b0;
`endif

    // Full-precision power; squares are non-negative so their sum cannot overflow PW bits
    function automatic logic [PW-1:0] power(input logic signed [DW-1:0] re,
                                            input logic signed [DW-1:0] im);
        logic signed [2*DW-1:0] rr;
        logic signed [2*DW-1:0] ii;
        rr = (2*DW)'(re) * (2*DW)'(re);
        ii = (2*DW)'(im) * (2*DW)'(im);
        return {1'b0, rr} + {1'b0, ii};
    endfunction

    logic [CW-1:0]       cnt_r;
    logic                s0_valid_r;
    logic [LANES*DW-1:0] s0_re_r;
    logic [LANES*DW-1:0] s0_im_r;
    logic [CW-1:0]       s0_beat_r;
    logic [PW-1:0]       s0_thresh_r;

    // Input capture and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= '0;
            s0_valid_r  <= 1'b0;
            s0_re_r     <= '0;
            s0_im_r     <= '0;
            s0_beat_r   <= '0;
            s0_thresh_r <= '0;
        end else begin
            s0_valid_r <= in_valid;
            if (in_valid) begin
                s0_re_r     <= in_re;
                s0_im_r     <= in_im;
                s0_beat_r   <= cnt_r;
                s0_thresh_r <= thresh;
                cnt_r       <= (cnt_r == CW'(BEATS - 1)) ? '0 : cnt_r + 1'b1;
            end
        end
    end

    logic [PW-1:0] lane_pwr_s [LANES];

    // Lane powers, with optional DC masking on beat 0 lane 0
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_pwr_s[l] = (DC_EXCL && (l == 0) && (s0_beat_r == '0)) ? '0
                          : power(s0_re_r[l*DW +: DW], s0_im_r[l*DW +: DW]);
        end
    end

    logic          s1_valid_r;
    logic [PW-1:0] s1_pwr_r [LANES];
    logic [CW-1:0] s1_beat_r;
    logic [PW-1:0] s1_thresh_r;

    // S1: register lane powers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_pwr_r    <= '{default: '0};
            s1_beat_r   <= '0;
            s1_thresh_r <= '0;
        end else begin
            s1_valid_r  <= s0_valid_r;
            s1_pwr_r    <= lane_pwr_s;
            s1_beat_r   <= s0_beat_r;
            s1_thresh_r <= s0_thresh_r;
        end
    end

    logic [PW-1:0] t_pwr_s [LANES];
    logic [LW-1:0] t_idx_s [LANES];
    logic [FW-1:0] win_idx_s;

    // Balanced tournament: the left (lower) lane keeps the slot unless strictly beaten
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            t_pwr_s[i] = s1_pwr_r[i];
            t_idx_s[i] = LW'(i);
        end
        for (int step = 1; step < LANES; step = step * 2) begin
            for (int i = 0; i < LANES; i = i + 2 * step) begin
                t_idx_s[i] = (t_pwr_s[i+step] > t_pwr_s[i]) ? t_idx_s[i+step] : t_idx_s[i];
                t_pwr_s[i] = (t_pwr_s[i+step] > t_pwr_s[i]) ? t_pwr_s[i+step] : t_pwr_s[i];
            end
        end
        win_idx_s = (FW'(s1_beat_r) << LSH) | FW'(t_idx_s[0]);
    end

    logic          s2_valid_r;
    logic          s2_first_r;
    logic          s2_last_r;
    logic [FW-1:0] s2_idx_r;
    logic [PW-1:0] s2_pwr_r;
    logic [PW-1:0] s2_thresh_r;

    // S2: register beat winner with frame position tags
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r  <= 1'b0;
            s2_first_r  <= 1'b0;
            s2_last_r   <= 1'b0;
            s2_idx_r    <= '0;
            s2_pwr_r    <= '0;
            s2_thresh_r <= '0;
        end else begin
            s2_valid_r  <= s1_valid_r;
            s2_first_r  <= (s1_beat_r == '0);
            s2_last_r   <= (s1_beat_r == CW'(BEATS - 1));
            s2_idx_r    <= win_idx_s;
            s2_pwr_r    <= t_pwr_s[0];
            s2_thresh_r <= s1_thresh_r;
        end
    end

    logic [FW-1:0] best_idx_r;
    logic [PW-1:0] best_pwr_r;
    logic          take_s;
    logic [FW-1:0] fin_idx_s;
    logic [PW-1:0] fin_pwr_s;

    // Frame merge: first beat loads, later beats replace only on strictly greater power
    always_comb begin
        take_s = s2_first_r || (s2_pwr_r > best_pwr_r);
        if (take_s) begin
            fin_idx_s = s2_idx_r;
            fin_pwr_s = s2_pwr_r;
        end else begin
            fin_idx_s = best_idx_r;
            fin_pwr_s = best_pwr_r;
        end
    end

    // S3: running best and registered frame result
    always_ff @(posedge clk) begin
        if (rst) begin
            best_idx_r <= '0;
            best_pwr_r <= '0;
            done       <= 1'b0;
            freq       <= '0;
            peak_pwr   <= '0;
            hit        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (s2_valid_r) begin
                best_idx_r <= fin_idx_s;
                best_pwr_r <= fin_pwr_s;
                if (s2_last_r) begin
                    done     <= 1'b1;
                    freq     <= fin_idx_s;
                    peak_pwr <= fin_pwr_s;
                    hit      <= (fin_pwr_s >= s2_thresh_r);
                end
            end
        end
    end
endmodule

// File: tb/tb_peak_bin_detector.sv
// Randomised bench for peak_bin_detector: a LANES=4 instance under a scoreboard
// monitor and a LANES=16 single-beat instance checked directly.
module tb_peak_bin_detector;
    localparam int DW   = 16;
    localparam int BINS = 16;
    localparam int LA   = 4;
    localparam int LB   = 16;
    localparam int PW   = 2 * DW + 1;
    localparam int NBA  = BINS / LA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             a_valid, a_done, a_hit;
    logic [LA*DW-1:0] a_re, a_im;
    logic [PW-1:0]    a_thresh, a_pwr;
    logic [3:0]       a_freq;
    logic             b_valid, b_done, b_hit;
    logic [LB*DW-1:0] b_re, b_im;
    logic [PW-1:0]    b_thresh, b_pwr;
    logic [3:0]       b_freq;

    peak_bin_detector #(.BINS(BINS), .LANES(LA), .DW(DW)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_re(a_re), .in_im(a_im),
        .thresh(a_thresh), .done(a_done), .freq(a_freq), .peak_pwr(a_pwr), .hit(a_hit));

    peak_bin_detector #(.BINS(BINS), .LANES(LB), .DW(DW)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_re(b_re), .in_im(b_im),
        .thresh(b_thresh), .done(b_done), .freq(b_freq), .peak_pwr(b_pwr), .hit(b_hit));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int     fr_re[BINS];
    int     fr_im[BINS];
    int     bpos = 0;
    int     cyc  = 0;
    int     n_done = 0;
    int     q_freq[$];
    longint q_pwr[$];
    bit     q_hit[$];
    int     q_cyc[$];
    int     last_f = 0;
    longint last_p = 0;
    bit     last_h = 1'b0;

    function automatic longint bin_pwr(input int i);
        longint p;
        p = longint'(fr_re[i]) * fr_re[i] + longint'(fr_im[i]) * fr_im[i];
`ifdef PBD_DC_EXCLUDE_EN
        if (i == 0) p = 0;
`endif
        return p;
    endfunction

    // Linear scan argmax; strict > keeps the lowest index on ties
    function automatic void golden(output int f, output longint p);
        f = 0;
        p = bin_pwr(0);
        for (int i = 1; i < BINS; i++) begin
            if (bin_pwr(i) > p) begin
                f = i;
                p = bin_pwr(i);
            end
        end
    endfunction

    function automatic int rnd_comp(input int mode);
        if (mode == 0) return int'($urandom_range(0, 65535)) - 32768;
        else if (mode == 1) return int'($urandom_range(0, 6)) - 3;
        else return int'($urandom_range(0, 1000)) - 500;
    endfunction

    function automatic void fill(input int mode);
        for (int i = 0; i < BINS; i++) begin
            fr_re[i] = rnd_comp(mode);
            fr_im[i] = rnd_comp(mode);
        end
    endfunction

    function automatic void fill_const(input int re, input int im);
        for (int i = 0; i < BINS; i++) begin
            fr_re[i] = re;
            fr_im[i] = im;
        end
    endfunction

    // Scoreboard for dut_a, sampled 1 time unit after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                q_freq.delete(); q_pwr.delete(); q_hit.delete(); q_cyc.delete();
                last_f = 0; last_p = 0; last_h = 1'b0;
                check("rst_a_out", {a_done, a_hit, a_pwr, a_freq}, 64'd0);
                check("rst_b_out", {b_done, b_hit, b_pwr, b_freq}, 64'd0);
            end else if (a_done) begin
                n_done++;
                if (q_cyc.size() == 0) begin
                    check("spurious_done", 64'd1, 64'd0);
                end else begin
                    check("done_cycle", cyc, q_cyc[0]);
                    check("freq", a_freq, q_freq[0]);
                    check("peak_pwr", a_pwr, q_pwr[0]);
                    check("hit", a_hit, q_hit[0]);
                    last_f = q_freq.pop_front();
                    last_p = q_pwr.pop_front();
                    last_h = q_hit.pop_front();
                    void'(q_cyc.pop_front());
                end
            end else begin
                while (q_cyc.size() > 0 && cyc >= q_cyc[0]) begin
                    check("missing_done", cyc, 64'd0);
                    void'(q_freq.pop_front()); void'(q_pwr.pop_front());
                    void'(q_hit.pop_front()); void'(q_cyc.pop_front());
                end
                check("hold", {a_hit, a_pwr, a_freq}, {last_h, last_p[PW-1:0], last_f[3:0]});
            end
        end
    end

    // Drive one beat of the current frame into dut_a; thr applies only to a last beat
    task automatic send_a(input longint thr);
        int     f;
        int     v;
        longint p;
        for (int l = 0; l < LA; l++) begin
            v = fr_re[bpos*LA + l]; a_re[l*DW +: DW] = v[DW-1:0];
            v = fr_im[bpos*LA + l]; a_im[l*DW +: DW] = v[DW-1:0];
        end
        a_valid = 1'b1;
        if (bpos == NBA - 1) begin
            a_thresh = thr[PW-1:0];
            golden(f, p);
            q_freq.push_back(f);
            q_pwr.push_back(p);
            q_hit.push_back(p >= thr);
            q_cyc.push_back(cyc + 4);
        end else begin
            a_thresh = PW'($urandom);
        end
        bpos = (bpos + 1) % NBA;
        @(negedge clk);
        a_valid  = 1'b0;
        a_thresh = PW'($urandom);
    endtask

    task automatic frame_a(input longint thr);
        for (int b = 0; b < NBA; b++) send_a(thr);
    endtask

    // One full frame in a single beat through dut_b, checked at a fixed latency
    task automatic run_b(input longint thr);
        int     f;
        int     v;
        longint p;
        for (int l = 0; l < LB; l++) begin
            v = fr_re[l]; b_re[l*DW +: DW] = v[DW-1:0];
            v = fr_im[l]; b_im[l*DW +: DW] = v[DW-1:0];
        end
        b_valid  = 1'b1;
        b_thresh = thr[PW-1:0];
        golden(f, p);
        @(negedge clk);
        b_valid  = 1'b0;
        b_thresh = PW'($urandom);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("b_early", b_done, 64'd0);
        @(posedge clk); #1;
        check("b_done", b_done, 64'd1);
        check("b_freq", b_freq, f);
        check("b_pwr", b_pwr, p);
        check("b_hit", b_hit, p >= thr);
        @(negedge clk);
    endtask

    int     gf;
    longint gp;
    longint thr;
    int     base;

    initial begin
        a_valid = 1'b0; a_re = '0; a_im = '0; a_thresh = '0;
        b_valid = 1'b0; b_re = '0; b_im = '0; b_thresh = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single-beat frames: bin 5 = (100,-200) among (10,10), then random
        fill_const(10, 10);
        fr_re[5] = 100; fr_im[5] = -200;
        run_b(0);
        check("b_t1_freq_const", b_freq, 64'd5);
        check("b_t1_pwr_const", b_pwr, 64'd50000);
        for (int k = 0; k < 6; k++) begin
            fill(k % 3);
            golden(gf, gp);
            run_b((k % 2 == 0) ? gp : gp + 1);
        end

        // Gapped beats with full-scale peak at bin 13
        fill(2);
        fr_re[13] = -32768; fr_im[13] = -32768;
        send_a(0); send_a(0);
        repeat (2) @(negedge clk);
        send_a(0);
        repeat (5) @(negedge clk);
        send_a(0);
        repeat (6) @(negedge clk);
        check("gap_pwr_const", a_pwr, 64'd2147483648);
        check("gap_freq_const", a_freq, 64'd13);

        // Ties resolve to the lower index
        fill_const(0, 0);
        fr_re[6] = 300; fr_re[9] = 300;
        frame_a(0);
        fill_const(0, 0);
        fr_re[2] = 300; fr_re[3] = 300;
        frame_a(0);
        repeat (6) @(negedge clk);
        check("tie_freq_const", a_freq, 64'd2);

        // Threshold boundary around a 50000 peak at bin 7
        fill_const(10, 10);
        fr_re[7] = 100; fr_im[7] = 200;
        frame_a(50001);
        frame_a(50000);
        frame_a(49999);
        repeat (6) @(negedge clk);

        // Large DC bin: excluded or not depending on the build
        fill(2);
        fr_re[0] = 1000; fr_im[0] = 0;
        frame_a(0);
        repeat (6) @(negedge clk);

        // Reset after two beats of four discards the partial frame
        fill(0);
        send_a(0); send_a(0);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        bpos = 0;
        fill(0);
        frame_a(0);
        repeat (6) @(negedge clk);

        // Back-to-back random frames at full rate
        base = n_done;
        for (int k = 0; k < 64; k++) begin
            fill((k % 4 == 0) ? 1 : ((k % 4 == 1) ? 2 : 0));
            golden(gf, gp);
            case (k % 3)
                0: thr = gp;
                1: thr = gp + 1;
                default: thr = longint'($urandom);
            endcase
            frame_a(thr);
        end
        repeat (8) @(negedge clk);
        check("b2b_count", n_done - base, 64'd64);
        check("pending", q_cyc.size(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
